vc_dest_arbiter: RTL and testbench
==================================

// Module: vc_dest_arbiter
// PURPOSE
//  Stage directly downstream of the initial (main FIFO -> VC0/VC1 FIFO) logic.
//  Drains the VC0 and VC1 FIFOs, VC0 priority with an anti-starvation burst limit,
//  and routes each word to destination FIFO D0 or D1 by its destination bit.
//  Honours D0/D1 almost_full backpressure and keeps per-destination word counts.
// PARAMETERS
//  data_width     6   word width, same as the VC FIFOs
//  DEST_BIT       4   bit index of data word selecting D0 (0) or D1 (1)
//  MAX_VC0_BURST  4   consecutive VC0 pops allowed while VC1 non-empty, then one VC1 pop
//  CNT_WIDTH      8   width of count_D0/count_D1
// PORTS
//  clk              in   1           rising-edge clock
//  reset            in   1           synchronous, active-high
//  empty_fifo_VC0   in   1           VC0 FIFO empty
//  empty_fifo_VC1   in   1           VC1 FIFO empty
//  data_out_VC0     in   data_width  VC0 read data, valid cycle after pop_VC0_fifo
//  data_out_VC1     in   data_width  VC1 read data, valid cycle after pop_VC1_fifo
//  almost_full_D0   in   1           D0 FIFO almost full
//  almost_full_D1   in   1           D1 FIFO almost full
//  pop_VC0_fifo     out  1           read strobe to VC0 FIFO
//  pop_VC1_fifo     out  1           read strobe to VC1 FIFO
//  push_D0          out  1           write strobe to D0 FIFO
//  push_D1          out  1           write strobe to D1 FIFO
//  data_D0          out  data_width  write data to D0
//  data_D1          out  data_width  write data to D1
//  idle             out  1           no pops/pushes in flight, both VC FIFOs empty
//  count_D0         out  CNT_WIDTH   words pushed to D0 since reset, wraps
//  count_D1         out  CNT_WIDTH   words pushed to D1 since reset, wraps
// BEHAVIOUR
//  - Synchronous, active-high reset (sampled on rising edge of clk, reset=1).
//  - Reset: pop_*/push_* = 0, data_D0/D1 = 0, counts = 0, burst counter = 0,
//    FSM = IDLE, idle = 1; in-flight words discarded (never pushed).
//  - FSM: IDLE -> ACTIVE when either VC FIFO non-empty; ACTIVE -> IDLE when both
//    empty and pipeline drained; ACTIVE -> STALL when almost_full_D0|almost_full_D1;
//    STALL -> ACTIVE when both deasserted (and a VC non-empty, else -> IDLE).
//  - Pop rule (combinational, cycle N): pop only in ACTIVE, only if !almost_full_D0
//    && !almost_full_D1; at most one pop per cycle; never pop an empty FIFO.
//  - Select: VC0 if non-empty, unless burst counter == MAX_VC0_BURST and VC1
//    non-empty -> VC1. Burst counter +1 per VC0 pop while VC1 non-empty; cleared
//    on VC1 pop or when VC1 empty.
//  - Pipeline: pop cycle N, data_out_VCx sampled at end of N+1, push_Dy and data_Dy
//    registered high in N+2 for exactly one cycle. Latency pop->push = 2 cycles;
//    back-to-back pops yield back-to-back pushes. Up to 2 words in flight, so
//    D0/D1 almost_full thresholds must leave >= 2 free entries.
//  - Routing: word[DEST_BIT]=0 -> D0, =1 -> D1; exactly one push per popped word.
//    data_Dy holds last pushed value when push_Dy = 0.
//  - Counters: count_Dy +1 on each push_Dy; wraps 2^CNT_WIDTH-1 -> 0.
//  - almost_full asserting while words in flight: in-flight words still pushed;
//    new pops stop same cycle.
//  - idle = 1 iff FSM IDLE and no words in flight.
// TESTING
//  1 Reset held 3 cycles, both VC empty -> all strobes 0, idle=1, counts 0.
//  2 VC0 holds 6'h01,6'h12 (bit4=0,1) -> pops 2 consecutive cycles; push_D0 data
//    6'h01 then push_D1 data 6'h12, each 2 cycles after its pop; counts 1/1.
//  3 VC0 holds 6 words, VC1 holds 6'h21 -> pop order VC0 x4, VC1, VC0 x2.
//  4 almost_full_D1=1 mid-stream -> no pops while high; in-flight words still
//    pushed; resumes the cycle after deassertion, no loss/duplication.
//  5 Reset asserted with 2 words in flight -> no push follows, counts 0, idle=1.
//  6 256 words to D0 -> count_D0 wraps to 0, count_D1 stays 0.

Source files
------------

// File: rtl/vc_dest_arbiter.sv
// -----------------------------------------------------------------------------
// vc_dest_arbiter
//
// Purpose:
//   Drains the VC0 and VC1 FIFOs one word per cycle and forwards each word to
//   destination FIFO D0 or D1, selected by bit DEST_BIT of the word. VC0 has
//   priority, but after MAX_VC0_BURST consecutive VC0 pops with VC1 waiting,
//   one VC1 pop is forced so VC1 cannot starve. Pops stop whenever either
//   destination reports almost_full. Words already popped are always
//   delivered. Per-destination push counters wrap.
//
// Timing:
//   pop in cycle N -> FIFO read data valid in N+1 (captured at end of N+1)
//   -> push_Dx/data_Dx high in N+2 for one cycle. At most two words are in
//   flight, so the D0/D1 almost_full thresholds must leave two free entries.
//
// Ports:
//   i_clk              rising-edge clock
//   i_reset            synchronous, active-high reset
//   i_empty_fifo_VC0   VC0 FIFO empty
//   i_empty_fifo_VC1   VC1 FIFO empty
//   i_data_out_VC0     VC0 read data, valid the cycle after a VC0 pop
//   i_data_out_VC1     VC1 read data, valid the cycle after a VC1 pop
//   i_almost_full_D0   D0 FIFO almost full
//   i_almost_full_D1   D1 FIFO almost full
//   o_pop_VC0_fifo     read strobe to VC0 (combinational)
//   o_pop_VC1_fifo     read strobe to VC1 (combinational)
//   o_push_D0          write strobe to D0 (registered)
//   o_push_D1          write strobe to D1 (registered)
//   o_data_D0          write data to D0, holds last pushed value
//   o_data_D1          write data to D1, holds last pushed value
//   o_idle             FSM idle and nothing in flight
//   o_count_D0         words pushed to D0 since reset (wraps)
//   o_count_D1         words pushed to D1 since reset (wraps)
// -----------------------------------------------------------------------------
module vc_dest_arbiter #(
  parameter int data_width    = 6,
  parameter int DEST_BIT      = 4,
  parameter int MAX_VC0_BURST = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_empty_fifo_VC0,
  input  logic                  i_empty_fifo_VC1,
  input  logic [data_width-1:0] i_data_out_VC0,
  input  logic [data_width-1:0] i_data_out_VC1,
  input  logic                  i_almost_full_D0,
  input  logic                  i_almost_full_D1,
  output logic                  o_pop_VC0_fifo,
  output logic                  o_pop_VC1_fifo,
  output logic                  o_push_D0,
  output logic                  o_push_D1,
  output logic [data_width-1:0] o_data_D0,
  output logic [data_width-1:0] o_data_D1,
  output logic                  o_idle,
  output logic [CNT_WIDTH-1:0]  o_count_D0,
  output logic [CNT_WIDTH-1:0]  o_count_D1
);

  localparam int BW = $clog2(MAX_VC0_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_VC0_BURST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  w_af;
  logic                  w_any_vc;
  logic                  w_can_pop;
  logic                  w_pick_vc1;
  logic                  w_pop_vc0;
  logic                  w_pop_vc1;
  logic                  w_pop_any;
  logic [BW-1:0]         r_burst;
  logic [BW-1:0]         w_burst_nxt;

  // stage 1: a word popped last cycle whose data is on the FIFO read port now
  logic                  r_s1_valid;
  logic                  r_s1_from_vc1;
  logic [data_width-1:0] w_s1_word;
  logic                  w_s1_to_d1;

  logic                  r_push_D0;
  logic                  r_push_D1;
  logic [data_width-1:0] r_data_D0;
  logic [data_width-1:0] r_data_D1;
  logic [CNT_WIDTH-1:0]  r_count_D0;
  logic [CNT_WIDTH-1:0]  r_count_D1;
  logic                  r_idle;

  assign w_af      = i_almost_full_D0 | i_almost_full_D1;
  assign w_any_vc  = ~i_empty_fifo_VC0 | ~i_empty_fifo_VC1;
  assign w_can_pop = (r_state == ST_ACTIVE) & ~w_af;
  assign w_pop_any = w_pop_vc0 | w_pop_vc1;

  assign w_s1_word  = r_s1_from_vc1 ? i_data_out_VC1 : i_data_out_VC0;
  assign w_s1_to_d1 = w_s1_word[DEST_BIT];

  // Source select and pop strobes
  always_comb begin
    w_pick_vc1 = 1'b0;
    w_pop_vc0  = 1'b0;
    w_pop_vc1  = 1'b0;
    // VC1 wins when VC0 has nothing, or VC0 has used up its burst allowance
    if (!i_empty_fifo_VC1 && (i_empty_fifo_VC0 || (r_burst == BURST_MAX))) begin
      w_pick_vc1 = 1'b1;
    end else begin
      w_pick_vc1 = 1'b0;
    end
    if (w_can_pop) begin
      w_pop_vc1 = w_pick_vc1 & ~i_empty_fifo_VC1;
      w_pop_vc0 = ~w_pick_vc1 & ~i_empty_fifo_VC0;
    end else begin
      w_pop_vc1 = 1'b0;
      w_pop_vc0 = 1'b0;
    end
  end

  // Anti-starvation burst counter next value
  always_comb begin
    w_burst_nxt = r_burst;
    if (i_empty_fifo_VC1 || w_pop_vc1) begin
      w_burst_nxt = '0;
    end else if (w_pop_vc0 && (r_burst != BURST_MAX)) begin
      w_burst_nxt = r_burst + BW'(1);
    end else begin
      w_burst_nxt = r_burst;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_vc) w_state_nxt = ST_ACTIVE;
        else          w_state_nxt = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (w_af)                         w_state_nxt = ST_STALL;
        else if (!w_any_vc && !r_s1_valid) w_state_nxt = ST_IDLE;
        else                              w_state_nxt = ST_ACTIVE;
      end
      ST_STALL: begin
        if (w_af)          w_state_nxt = ST_STALL;
        else if (w_any_vc) w_state_nxt = ST_ACTIVE;
        else               w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, burst counter and stage-1 tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_burst       <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_from_vc1 <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_burst       <= w_burst_nxt;
      r_s1_valid    <= w_pop_any;
      r_s1_from_vc1 <= w_pop_vc1;
    end
  end

  // Destination push strobes, data and counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_push_D0  <= 1'b0;
      r_push_D1  <= 1'b0;
      r_data_D0  <= '0;
      r_data_D1  <= '0;
      r_count_D0 <= '0;
      r_count_D1 <= '0;
    end else begin
      r_push_D0 <= r_s1_valid & ~w_s1_to_d1;
      r_push_D1 <= r_s1_valid & w_s1_to_d1;
      if (r_s1_valid && !w_s1_to_d1) begin
        r_data_D0  <= w_s1_word;
        r_count_D0 <= r_count_D0 + CNT_WIDTH'(1);
      end else begin
        r_data_D0  <= r_data_D0;
        r_count_D0 <= r_count_D0;
      end
      if (r_s1_valid && w_s1_to_d1) begin
        r_data_D1  <= w_s1_word;
        r_count_D1 <= r_count_D1 + CNT_WIDTH'(1);
      end else begin
        r_data_D1  <= r_data_D1;
        r_count_D1 <= r_count_D1;
      end
    end
  end

  // Idle flag, computed from next-cycle state so the output is registered:
  // a pop now becomes stage 1 next cycle, stage 1 now becomes a push next cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idle <= 1'b1;
    end else begin
      r_idle <= (w_state_nxt == ST_IDLE) & ~w_pop_any & ~r_s1_valid;
    end
  end

  assign o_pop_VC0_fifo = w_pop_vc0;
  assign o_pop_VC1_fifo = w_pop_vc1;
  assign o_push_D0      = r_push_D0;
  assign o_push_D1      = r_push_D1;
  assign o_data_D0      = r_data_D0;
  assign o_data_D1      = r_data_D1;
  assign o_idle         = r_idle;
  assign o_count_D0     = r_count_D0;
  assign o_count_D1     = r_count_D1;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_dest_arbiter
//
// Directed bench for vc_dest_arbiter. Two simple FIFO models feed the DUT
// (registered read data, one cycle after pop). A negedge monitor logs every
// pop and push with its cycle number; expected orders, latencies and counts
// are written out by hand below.
// -----------------------------------------------------------------------------
module tb_vc_dest_arbiter;

  logic       clk;
  logic       reset;
  logic       empty0;
  logic       empty1;
  logic [5:0] dout0;
  logic [5:0] dout1;
  logic       af0;
  logic       af1;
  logic       pop0;
  logic       pop1;
  logic       push_d0;
  logic       push_d1;
  logic [5:0] data_d0;
  logic [5:0] data_d1;
  logic       idle;
  logic [7:0] count_d0;
  logic [7:0] count_d1;

  vc_dest_arbiter dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_empty_fifo_VC0 (empty0),
    .i_empty_fifo_VC1 (empty1),
    .i_data_out_VC0   (dout0),
    .i_data_out_VC1   (dout1),
    .i_almost_full_D0 (af0),
    .i_almost_full_D1 (af1),
    .o_pop_VC0_fifo   (pop0),
    .o_pop_VC1_fifo   (pop1),
    .o_push_D0        (push_d0),
    .o_push_D1        (push_d1),
    .o_data_D0        (data_d0),
    .o_data_D1        (data_d1),
    .o_idle           (idle),
    .o_count_D0       (count_d0),
    .o_count_D1       (count_d1)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  // cycle counter, used to time-stamp logged events
  always @(posedge clk) cyc <= cyc + 1;

  // VC FIFO models: wr pointers written by the stimulus, rd pointers here
  logic [5:0] mem0 [0:511];
  logic [5:0] mem1 [0:511];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  assign empty0 = (wr0 == rd0);
  assign empty1 = (wr1 == rd1);

  // FIFO read side; reset flushes whatever is left
  always @(posedge clk) begin
    if (reset) begin
      rd0 <= wr0;
      rd1 <= wr1;
    end else begin
      if (pop0 && !empty0) begin
        dout0 <= mem0[rd0 % 512];
        rd0   <= rd0 + 1;
      end
      if (pop1 && !empty1) begin
        dout1 <= mem1[rd1 % 512];
        rd1   <= rd1 + 1;
      end
    end
  end

  // event logs
  int pop_vc[$];
  int pop_cyc[$];
  int d0_data[$];
  int d0_cyc[$];
  int d0_cnt[$];
  int d1_data[$];
  int d1_cyc[$];

  // monitor, sampling away from the active edge
  always @(negedge clk) begin
    if (pop0) begin pop_vc.push_back(0); pop_cyc.push_back(cyc); end
    if (pop1) begin pop_vc.push_back(1); pop_cyc.push_back(cyc); end
    if (push_d0) begin
      d0_data.push_back(int'(data_d0));
      d0_cyc.push_back(cyc);
      d0_cnt.push_back(int'(count_d0));
    end
    if (push_d1) begin
      d1_data.push_back(int'(data_d1));
      d1_cyc.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [5:0] w);
    mem0[wr0 % 512] = w;
    wr0 = wr0 + 1;
  endtask

  task automatic load1(input logic [5:0] w);
    mem1[wr1 % 512] = w;
    wr1 = wr1 + 1;
  endtask

  task automatic clear_logs();
    pop_vc.delete(); pop_cyc.delete();
    d0_data.delete(); d0_cyc.delete(); d0_cnt.delete();
    d1_data.delete(); d1_cyc.delete();
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (!(idle && empty0 && empty1) && n < limit) begin
      tick();
      n++;
    end
    check_value(tag, int'(idle), 1);
  endtask

  int exp_t3_vc [7]  = '{0, 0, 0, 0, 1, 0, 0};
  int exp_t3_d0 [4]  = '{'h02, 'h04, 'h21, 'h06};
  int exp_t3_d1 [3]  = '{'h13, 'h15, 'h17};
  int exp_t4_d0 [4]  = '{'h01, 'h03, 'h05, 'h07};
  int exp_t4_d1 [4]  = '{'h12, 'h14, 'h16, 'h18};

  int af_on, af_off, n, quiet_pops, stall_pushes, first_after;

  initial begin
    reset = 1'b1;
    af0   = 1'b0;
    af1   = 1'b0;

    // 1: reset held 3 cycles, both VCs empty
    repeat (3) tick();
    check_value("rst_pop0",  int'(pop0), 0);
    check_value("rst_pop1",  int'(pop1), 0);
    check_value("rst_push0", int'(push_d0), 0);
    check_value("rst_push1", int'(push_d1), 0);
    check_value("rst_idle",  int'(idle), 1);
    check_value("rst_cnt0",  int'(count_d0), 0);
    check_value("rst_cnt1",  int'(count_d1), 0);
    check_value("rst_data0", int'(data_d0), 0);
    check_value("rst_data1", int'(data_d1), 0);
    reset = 1'b0;
    tick();
    tick();

    // 2: two VC0 words, one per destination
    clear_logs();
    load0(6'h01);
    load0(6'h12);
    tick();
    wait_idle("t2_drain", 50);
    check_value("t2_npop", pop_vc.size(), 2);
    check_value("t2_pop_b2b", pop_cyc[1] - pop_cyc[0], 1);
    check_value("t2_d0_data", d0_data[0], 'h01);
    check_value("t2_d0_lat", d0_cyc[0] - pop_cyc[0], 2);
    check_value("t2_d1_data", d1_data[0], 'h12);
    check_value("t2_d1_lat", d1_cyc[0] - pop_cyc[1], 2);
    check_value("t2_cnt0", int'(count_d0), 1);
    check_value("t2_cnt1", int'(count_d1), 1);
    check_value("t2_hold0", int'(data_d0), 'h01);

    // 3: burst limit, VC0 x4, VC1, VC0 x2
    clear_logs();
    load0(6'h02); load0(6'h13); load0(6'h04);
    load0(6'h15); load0(6'h06); load0(6'h17);
    load1(6'h21);
    tick();
    wait_idle("t3_drain", 60);
    check_value("t3_npop", pop_vc.size(), 7);
    for (int i = 0; i < 7; i++) check_value($sformatf("t3_order%0d", i), pop_vc[i], exp_t3_vc[i]);
    check_value("t3_pop_span", pop_cyc[6] - pop_cyc[0], 6);
    check_value("t3_nd0", d0_data.size(), 4);
    for (int i = 0; i < 4; i++) check_value($sformatf("t3_d0_%0d", i), d0_data[i], exp_t3_d0[i]);
    check_value("t3_nd1", d1_data.size(), 3);
    for (int i = 0; i < 3; i++) check_value($sformatf("t3_d1_%0d", i), d1_data[i], exp_t3_d1[i]);
    check_value("t3_cnt0", int'(count_d0), 5);
    check_value("t3_cnt1", int'(count_d1), 4);

    // 4: almost_full_D1 mid-stream
    clear_logs();
    load0(6'h01); load0(6'h12); load0(6'h03); load0(6'h14);
    load0(6'h05); load0(6'h16); load0(6'h07); load0(6'h18);
    tick();
    n = 0;
    while (pop_cyc.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    check_value("t4_reach3", pop_cyc.size(), 3);
    af1   = 1'b1;
    af_on = cyc;
    repeat (4) tick();
    af1    = 1'b0;
    af_off = cyc;
    wait_idle("t4_drain", 60);
    quiet_pops   = 0;
    stall_pushes = 0;
    first_after  = -1;
    foreach (pop_cyc[i]) begin
      if (pop_cyc[i] >= af_on && pop_cyc[i] <= af_off) quiet_pops++;
      if (pop_cyc[i] > af_off && first_after < 0) first_after = pop_cyc[i];
    end
    foreach (d0_cyc[i]) if (d0_cyc[i] >= af_on && d0_cyc[i] <= af_off) stall_pushes++;
    foreach (d1_cyc[i]) if (d1_cyc[i] >= af_on && d1_cyc[i] <= af_off) stall_pushes++;
    check_value("t4_no_pop_stall", quiet_pops, 0);
    check_value("t4_inflight_pushed", stall_pushes, 2);
    check_value("t4_resume", first_after - af_off, 1);
    check_value("t4_npop", pop_vc.size(), 8);
    check_value("t4_nd0", d0_data.size(), 4);
    check_value("t4_nd1", d1_data.size(), 4);
    for (int i = 0; i < 4; i++) check_value($sformatf("t4_d0_%0d", i), d0_data[i], exp_t4_d0[i]);
    for (int i = 0; i < 4; i++) check_value($sformatf("t4_d1_%0d", i), d1_data[i], exp_t4_d1[i]);
    check_value("t4_cnt0", int'(count_d0), 9);
    check_value("t4_cnt1", int'(count_d1), 8);

    // 5: reset with two words in flight
    clear_logs();
    load0(6'h09); load0(6'h19); load0(6'h0A); load0(6'h1A);
    tick();
    n = 0;
    while (pop_cyc.size() < 1 && n < 50) begin
      tick();
      n++;
    end
    check_value("t5_started", pop_cyc.size(), 1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check_value("t5_no_push", d0_data.size() + d1_data.size(), 0);
    check_value("t5_cnt0", int'(count_d0), 0);
    check_value("t5_cnt1", int'(count_d1), 0);
    check_value("t5_idle", int'(idle), 1);
    check_value("t5_data0", int'(data_d0), 0);

    // 6: 256 words to D0, counter wraps
    clear_logs();
    for (int i = 0; i < 256; i++) load0(6'(i & 15));
    tick();
    wait_idle("t6_drain", 400);
    check_value("t6_nd0", d0_data.size(), 256);
    check_value("t6_nd1", d1_data.size(), 0);
    check_value("t6_pop_span", pop_cyc[255] - pop_cyc[0], 255);
    check_value("t6_cnt_255", d0_cnt[254], 255);
    check_value("t6_cnt_wrap", d0_cnt[255], 0);
    check_value("t6_last_data", d0_data[255], 15);
    check_value("t6_cnt0", int'(count_d0), 0);
    check_value("t6_cnt1", int'(count_d1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
